// File: rtl/kronos_dmem_resp.sv
// kronos_dmem_resp: wait-state data-memory responder for the Kronos LSU data bus
module kronos_dmem_resp #(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          DEPTH      = 1024,
   parameter int          RD_LATENCY = 1,
   parameter int          WR_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        data_req,
   input  logic [31:0] data_addr,
   input  logic        data_wr_en,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_mask,
   output logic [31:0] data_rd_data,
   output logic        data_ack,
   input  logic        stall,
   output logic        bus_err,
   input  logic        err_clr
);
   localparam int IW = $clog2(DEPTH);
   localparam int LMAX = RD_LATENCY > WR_LATENCY ? RD_LATENCY : WR_LATENCY;
   localparam int CW = LMAX > 1 ? $clog2(LMAX) : 1;
   localparam logic [CW-1:0] RD_CNT = CW'(RD_LATENCY - 1);
   localparam logic [CW-1:0] WR_CNT = CW'(WR_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   addr_q, wdata_q, addr, wdata, off;
   logic [3:0]    mask_q, mask;
   logic          we_q, we, in_range, enter_ack, unused_bits;
   logic [IW-1:0] idx;
   logic [31:0]   ram [DEPTH];

   // the capture edge can also be the ACK-entry edge, so IDLE uses the live payload
   assign addr        = state == IDLE ? data_addr : addr_q;
   assign wdata       = state == IDLE ? data_wr_data : wdata_q;
   assign mask        = state == IDLE ? data_mask : mask_q;
   assign we          = state == IDLE ? data_wr_en : we_q;
   assign off         = addr - BASE_ADDR;
   assign in_range    = off[31:IW+2] == '0;
   assign idx         = off[IW+1:2];
   assign unused_bits = ^off[1:0];
   assign enter_ack   = state != ACK && state_n == ACK;
   assign data_ack    = state == ACK;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: if (data_req) begin
            cnt_n   = data_wr_en ? WR_CNT : RD_CNT;
            state_n = (cnt_n == '0 && !stall) ? ACK : WAIT;
         end
         WAIT: if (!stall) begin
            state_n = cnt == '0 ? ACK : WAIT;
            cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         we_q         <= 1'b0;
         data_rd_data <= '0;
         bus_err      <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == IDLE && data_req) begin
            addr_q  <= data_addr;
            wdata_q <= data_wr_data;
            mask_q  <= data_mask;
            we_q    <= data_wr_en;
         end
         if (enter_ack && !we)
            data_rd_data <= in_range ? ram[idx] : '0;
         if (enter_ack && !in_range)
            bus_err <= 1'b1;
         else if (err_clr)
            bus_err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (enter_ack && we && in_range)
         for (int k = 0; k < 4; k++)
            if (mask[k])
               ram[idx][8*k +: 8] <= wdata[8*k +: 8];
   end
endmodule

// File: tb/tb_kronos_dmem_resp.sv
// tb_kronos_dmem_resp: table, directed and random checks of kronos_dmem_resp
module tb_kronos_dmem_resp;
   localparam logic [31:0] BASE = 32'h1000;
   localparam int DEPTH = 16;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] wdat;
      logic [3:0]  m;
      logic [7:0]  st;
      bit          c;
      logic [31:0] rd;
      int          lat;
      bit          e;
   } vec_t;

   logic        clk = 0, rstz = 0;
   logic        req [2], we [2], stl [2], clr [2], ack [2], err [2];
   logic [31:0] addr [2], wd [2], rd [2];
   logic [3:0]  msk [2];
   logic [31:0] mem [2][DEPTH];
   bit          merr [2];
   int          ncmp = 0, nbad = 0;
   vec_t        tbl [13];

   always #5 clk = ~clk;

   kronos_dmem_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(3), .WR_LATENCY(4)) u_slow (
      .clk(clk), .rstz(rstz), .data_req(req[0]), .data_addr(addr[0]), .data_wr_en(we[0]),
      .data_wr_data(wd[0]), .data_mask(msk[0]), .data_rd_data(rd[0]), .data_ack(ack[0]),
      .stall(stl[0]), .bus_err(err[0]), .err_clr(clr[0]));

   kronos_dmem_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(1), .WR_LATENCY(1)) u_fast (
      .clk(clk), .rstz(rstz), .data_req(req[1]), .data_addr(addr[1]), .data_wr_en(we[1]),
      .data_wr_data(wd[1]), .data_mask(msk[1]), .data_rd_data(rd[1]), .data_ack(ack[1]),
      .stall(stl[1]), .bus_err(err[1]), .err_clr(clr[1]));

   function automatic int rlat(int d);
      return d == 0 ? 3 : 1;
   endfunction

   function automatic int wlat(int d);
      return d == 0 ? 4 : 1;
   endfunction

   // ack edge = capture edge for an unstalled single-cycle access, else the L-th unstalled edge after capture
   function automatic int exp_lat(int l, logic [7:0] st);
      int n = 0;
      if (l == 1 && !st[0]) return 0;
      for (int k = 1; k < 40; k++) begin
         if (k > 7 || !st[k]) n++;
         if (n == l) return k;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rd_model(int d, logic [31:0] a);
      logic [31:0] off = a - BASE;
      return off < 4 * DEPTH ? mem[d][int'(off >> 2)] : 32'h0;
   endfunction

   task automatic mdl(input int d, input bit w, input logic [31:0] a, input logic [31:0] wdat, input logic [3:0] m);
      logic [31:0] off = a - BASE;
      if (off >= 4 * DEPTH) merr[d] = 1;
      else if (w)
         for (int k = 0; k < 4; k++)
            if (m[k]) mem[d][int'(off >> 2)][8*k +: 8] = wdat[8*k +: 8];
   endtask

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask

   task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wdat,
                       input logic [3:0] m, input logic [7:0] st, input bit c, input bit chg,
                       output logic [31:0] o_rd, output int o_lat, output logic o_err);
      o_rd = '0;
      o_err = 0;
      o_lat = -1;
      we[d] = w; addr[d] = a; wd[d] = wdat; msk[d] = m; clr[d] = c; stl[d] = st[0]; req[d] = 1;
      for (int k = 0; k < 40 && o_lat < 0; k++) begin
         @(posedge clk); #1;
         stl[d] = (k + 1 < 8) ? st[k+1] : 1'b0;
         if (chg && k == 0) begin
            req[d] = 0; addr[d] = addr[d] ^ 32'h4; wd[d] = ~wd[d];
         end
         if (ack[d]) begin
            o_lat = k; o_rd = rd[d]; o_err = err[d];
         end
      end
      req[d] = 0; stl[d] = 0; clr[d] = 0;
      @(posedge clk); #1;
      check("ack_one_cycle", ack[d], 0);
   endtask

   task automatic run(input int d, input bit w, input logic [31:0] a, input logic [31:0] wdat,
                      input logic [3:0] m, input logic [7:0] st, input bit chg);
      logic [31:0] o_rd, erd;
      logic o_err;
      int o_lat, el;
      el = exp_lat(w ? wlat(d) : rlat(d), st);
      erd = rd_model(d, a);
      xact(d, w, a, wdat, m, st, 0, chg, o_rd, o_lat, o_err);
      mdl(d, w, a, wdat, m);
      check("latency", o_lat, el);
      if (!w) check("rdata", o_rd, erd);
      check("bus_err", o_err, merr[d]);
   endtask

   initial begin
      logic [31:0] o_rd, a;
      logic o_err;
      int o_lat, n, last;
      tbl[0]  = '{1, 32'h1008, 32'h11223344, 4'hF, 8'h00, 0, 32'h0,        4, 0};
      tbl[1]  = '{1, 32'h1008, 32'hAABBCCDD, 4'h5, 8'h00, 0, 32'h0,        4, 0};
      tbl[2]  = '{0, 32'h1008, 32'h0,        4'h0, 8'h00, 0, 32'h11BB33DD, 3, 0};
      tbl[3]  = '{0, 32'h1008, 32'h0,        4'h0, 8'h06, 0, 32'h11BB33DD, 5, 0};
      tbl[4]  = '{1, 32'h1008, 32'hFFFFFFFF, 4'h0, 8'h00, 0, 32'h0,        4, 0};
      tbl[5]  = '{0, 32'h100A, 32'h0,        4'h0, 8'h00, 0, 32'h11BB33DD, 3, 0};
      tbl[6]  = '{0, 32'h1040, 32'h0,        4'h0, 8'h00, 0, 32'h0,        3, 1};
      tbl[7]  = '{1, 32'h0FFC, 32'hDEADBEEF, 4'hF, 8'h18, 0, 32'h0,        6, 1};
      tbl[8]  = '{0, 32'h103C, 32'h0,        4'h0, 8'h00, 0, 32'h5A5A000F, 3, 1};
      tbl[9]  = '{0, 32'h1004, 32'h0,        4'h0, 8'h01, 0, 32'h5A5A0001, 3, 1};
      tbl[10] = '{0, 32'h1004, 32'h0,        4'h0, 8'h00, 1, 32'h5A5A0001, 3, 0};
      tbl[11] = '{0, 32'h1040, 32'h0,        4'h0, 8'h00, 1, 32'h0,        3, 1};
      tbl[12] = '{0, 32'h1004, 32'h0,        4'h0, 8'h00, 0, 32'h5A5A0001, 3, 1};
      for (int d = 0; d < 2; d++) begin
         req[d] = 0; we[d] = 0; stl[d] = 0; clr[d] = 0; addr[d] = 0; wd[d] = 0; msk[d] = 0; merr[d] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_ack", ack[d], 0);
         check("reset_rdata", rd[d], 0);
         check("reset_err", err[d], 0);
      end
      rstz = 1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            run(d, 1, BASE + 32'(4 * i), 32'h5A5A0000 + 32'(i), 4'hF, 8'h00, 0);

      for (int i = 0; i < 13; i++) begin
         xact(0, tbl[i].w, tbl[i].a, tbl[i].wdat, tbl[i].m, tbl[i].st, tbl[i].c, 0, o_rd, o_lat, o_err);
         mdl(0, tbl[i].w, tbl[i].a, tbl[i].wdat, tbl[i].m);
         check($sformatf("tbl%0d_lat", i), o_lat, tbl[i].lat);
         if (!tbl[i].w) check($sformatf("tbl%0d_rdata", i), o_rd, tbl[i].rd);
         check($sformatf("tbl%0d_err", i), o_err, tbl[i].e);
      end
      merr[0] = 1;

      clr[0] = 1;
      @(posedge clk); #1;
      clr[0] = 0;
      merr[0] = 0;
      check("err_clr", err[0], 0);
      run(0, 0, 32'h1040, 0, 0, 8'h00, 0);
      run(0, 0, 32'h1004, 0, 0, 8'h00, 0);

      we[0] = 1; addr[0] = 32'h1010; wd[0] = 32'hCAFEF00D; msk[0] = 4'hF; req[0] = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("wait_no_ack", ack[0], 0);
      #3 rstz = 0;
      #1;
      check("arst_ack", ack[0], 0);
      check("arst_rdata", rd[0], 0);
      check("arst_err", err[0], 0);
      req[0] = 0;
      #2 rstz = 1;
      merr[0] = 0; merr[1] = 0;
      @(posedge clk); #1;
      check("post_reset_idle", ack[0], 0);
      run(0, 0, 32'h1010, 0, 0, 8'h00, 0);

      run(0, 0, 32'h1014, 0, 0, 8'h00, 1);
      run(0, 1, 32'h1020, 32'h12345678, 4'hF, 8'h00, 1);
      run(0, 0, 32'h1020, 0, 0, 8'h00, 0);
      run(0, 0, 32'h1024, 0, 0, 8'h00, 0);

      req[1] = 1; we[1] = 0; addr[1] = BASE;
      n = 0;
      last = 0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         @(posedge clk); #1;
         if (ack[1]) begin
            check("b2b_rdata", rd[1], mem[1][n]);
            if (n > 0) check("b2b_gap", 32'(c - last), 2);
            last = c;
            n++;
            addr[1] = BASE + 32'(4 * n);
         end
      end
      req[1] = 0;
      check("b2b_count", 32'(n), 4);
      @(posedge clk); #1;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 7);
            a = n == 0 ? BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15))
              : n == 1 ? BASE - 32'd4 - 32'(4 * $urandom_range(0, 15))
              : BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            run(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 8'($urandom), 0);
         end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
